// File: rtl/bsr_bank.sv
// Boundary-scan bank: NUM_CH data channels plus a per-channel override mask in one serial chain,
// with sample-and-hold observe, selective override and a shift-length check on update.
module bsr_bank #(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 32,
    parameter int STRICT = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    capture_dr,
    input  logic                    shift_dr,
    input  logic                    update_dr,
    input  logic [1:0]              mode,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic [NUM_CH*WIDTH-1:0] parallel_in,
    output logic [NUM_CH*WIDTH-1:0] parallel_out,
    output logic                    len_err,
    output logic                    upd_valid
);

    localparam int DW = NUM_CH * WIDTH;
    localparam int L  = NUM_CH * (WIDTH + 1);
    localparam int CW = $clog2(L + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(L);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] MODE_FUNC   = 2'b00;
    localparam logic [1:0] MODE_EXTEST = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_SELECT = 2'b11;

    logic [L-1:0]      chain;
    logic [DW-1:0]     upd_data;
    logic [NUM_CH-1:0] upd_mask;
    logic [DW-1:0]     hold;
    logic [CW-1:0]     cnt;
    logic              len_ok;
    logic              accept;

    assign len_ok = (cnt == CNT_FULL);
    // A lenient bank applies every update and only reports the bad length.
    assign accept = len_ok || (STRICT == 0);
    assign tdo    = chain[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain     <= '0;
            upd_data  <= '0;
            upd_mask  <= '0;
            hold      <= '0;
            cnt       <= '0;
            len_err   <= 1'b0;
            upd_valid <= 1'b0;
        end else if (capture_dr) begin
            chain <= {upd_mask, parallel_in};
            hold  <= parallel_in;
            cnt   <= '0;
        end else if (update_dr) begin
            if (accept) begin
                upd_data  <= chain[DW-1:0];
                upd_mask  <= chain[L-1:DW];
                upd_valid <= 1'b1;
            end
            len_err <= !len_ok;
        end else if (shift_dr) begin
            chain <= {tdi, chain[L-1:1]};
            // Saturate so an overlong shift can never alias back onto a good length.
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        parallel_out = parallel_in;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode)
                MODE_FUNC:   parallel_out[i*WIDTH +: WIDTH] = parallel_in[i*WIDTH +: WIDTH];
                MODE_EXTEST: parallel_out[i*WIDTH +: WIDTH] = upd_data[i*WIDTH +: WIDTH];
                MODE_HOLD:   parallel_out[i*WIDTH +: WIDTH] = hold[i*WIDTH +: WIDTH];
                MODE_SELECT: parallel_out[i*WIDTH +: WIDTH] = upd_mask[i] ? upd_data[i*WIDTH +: WIDTH]
                                                                           : parallel_in[i*WIDTH +: WIDTH];
                default:     parallel_out[i*WIDTH +: WIDTH] = parallel_in[i*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: tb/tb_bsr_bank.sv
// Directed bench for bsr_bank with NUM_CH=2, WIDTH=4 (L=10); a strict and a lenient bank share stimulus.
module tb_bsr_bank;

    logic       clk;
    logic       reset_n;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [1:0] mode;
    logic       tdi;
    logic [7:0] pin;

    logic       tdo1, tdo0;
    logic [7:0] pout1, pout0;
    logic       le1, le0;
    logic       uv1, uv0;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] vmode;
        logic [7:0] vin;
        logic [7:0] vexp;
    } vec_t;

    vec_t vt[9];

    bsr_bank #(.NUM_CH(2), .WIDTH(4), .STRICT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .tdi(tdi), .tdo(tdo1),
        .parallel_in(pin), .parallel_out(pout1), .len_err(le1), .upd_valid(uv1)
    );

    bsr_bank #(.NUM_CH(2), .WIDTH(4), .STRICT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .tdi(tdi), .tdo(tdo0),
        .parallel_in(pin), .parallel_out(pout0), .len_err(le0), .upd_valid(uv0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_capture();
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
    endtask

    task automatic do_update();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic shift_n(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            tdi      = bits[i];
            shift_dr = 1'b1;
            tick();
        end
        shift_dr = 1'b0;
    endtask

    logic [7:0]  a5;
    logic [9:0]  cap;
    logic [31:0] seq;

    initial begin
        checks = 0;
        errors = 0;

        vt[0] = '{2'b00, 8'h12, 8'h12};
        vt[1] = '{2'b01, 8'h12, 8'h69};
        vt[2] = '{2'b10, 8'h12, 8'hF0};
        vt[3] = '{2'b11, 8'h12, 8'h19};
        vt[4] = '{2'b11, 8'hF0, 8'hF9};
        vt[5] = '{2'b00, 8'hFF, 8'hFF};
        vt[6] = '{2'b11, 8'h00, 8'h09};
        vt[7] = '{2'b01, 8'h00, 8'h69};
        vt[8] = '{2'b10, 8'hAB, 8'hF0};

        // Reset with every strobe asserted
        reset_n = 1'b0; capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
        mode = 2'b00; tdi = 1'b1; pin = 8'h5A;
        tick();
        tick();
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        chk("reset_tdo", tdo1, 1'b0);
        chk("reset_len_err", le1, 1'b0);
        chk("reset_upd_valid", uv1, 1'b0);
        mode = 2'b01; #1;
        chk("reset_mode01", pout1, 8'h00);
        mode = 2'b00; #1;
        chk("reset_mode00", pout1, 8'h5A);
        reset_n = 1'b1;
        tick();

        // Sample and hold
        pin = 8'hA5; a5 = 8'hA5;
        do_capture();
        pin = 8'h3C;
        chk("sh_tdo_0", tdo1, a5[0]);
        for (int k = 1; k < 8; k++) begin
            shift_n(32'h0, 1);
            chk($sformatf("sh_tdo_%0d", k), tdo1, a5[k]);
        end
        mode = 2'b10; #1;
        chk("sh_hold", pout1, 8'hA5);

        // Extest load
        do_capture();
        shift_n(32'b11_0110_1001, 10);
        do_update();
        chk("ext_upd_valid", uv1, 1'b1);
        chk("ext_len_err", le1, 1'b0);
        mode = 2'b01; #1;
        chk("ext_out", pout1, 8'h69);
        chk("ext_out_lenient", pout0, 8'h69);

        // Selective load, then table of mode/input combinations
        pin = 8'hF0;
        do_capture();
        shift_n(32'b01_0110_1001, 10);
        do_update();
        mode = 2'b11; #1;
        chk("sel_out", pout1, 8'hF9);
        for (int v = 0; v < 9; v++) begin
            mode = vt[v].vmode;
            pin  = vt[v].vin;
            #1;
            chk($sformatf("vec%0d", v), pout1, vt[v].vexp);
        end

        // Short shift: strict bank rejects, lenient bank applies
        pin = 8'hF0;
        do_capture();
        shift_n(32'b0_1010_1010, 9);
        do_update();
        chk("short_len_err_strict", le1, 1'b1);
        chk("short_len_err_lenient", le0, 1'b1);
        chk("short_upd_valid_strict", uv1, 1'b1);
        mode = 2'b01; #1;
        chk("short_data_strict", pout1, 8'h69);
        chk("short_data_lenient", pout0, 8'h54);
        mode = 2'b11; pin = 8'hF0; #1;
        chk("short_sel_lenient", pout0, 8'hF4);

        // Capture and shift together: capture wins, counter restarts
        pin = 8'h5A; mode = 2'b00;
        cap = {2'b01, 8'h5A};
        capture_dr = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
        tick();
        capture_dr = 1'b0; shift_dr = 1'b0;
        chk("pri_len_err_sticky", le1, 1'b1);
        chk("pri_cap_tdo_0", tdo1, cap[0]);
        seq = 32'b11_0110_1001;
        for (int k = 1; k <= 9; k++) begin
            shift_n(seq >> (k - 1), 1);
            chk($sformatf("pri_cap_tdo_%0d", k), tdo1, cap[k]);
        end
        shift_n(seq >> 9, 1);
        do_update();
        chk("pri_cap_len_err", le1, 1'b0);
        chk("pri_cap_len_err_lenient", le0, 1'b0);
        mode = 2'b01; #1;
        chk("pri_cap_data", pout1, 8'h69);

        // Update and shift together after a full load: update wins, chain and count untouched
        pin = 8'h00;
        do_capture();
        shift_n(32'b10_1100_0011, 10);
        update_dr = 1'b1; shift_dr = 1'b1; tdi = 1'b0;
        tick();
        update_dr = 1'b0; shift_dr = 1'b0;
        chk("pri_upd_tdo", tdo1, 1'b1);
        chk("pri_upd_len_err", le1, 1'b0);
        mode = 2'b01; #1;
        chk("pri_upd_data", pout1, 8'hC3);
        do_update();
        chk("pri_upd_cnt_kept", le1, 1'b0);
        mode = 2'b11; pin = 8'h00; #1;
        chk("pri_upd_sel", pout1, 8'hC0);

        // Overlong shift: 26 bits would alias to 10 on a wrapping 4-bit counter
        do_capture();
        shift_n(32'b00_1111_1111 << 16, 26);
        do_update();
        chk("long_len_err_strict", le1, 1'b1);
        chk("long_len_err_lenient", le0, 1'b1);
        mode = 2'b01; #1;
        chk("long_data_strict", pout1, 8'hC3);
        chk("long_data_lenient", pout0, 8'hFF);

        // Reset in the middle of a shift
        pin = 8'h77;
        do_capture();
        shift_n(32'b111, 3);
        reset_n = 1'b0; shift_dr = 1'b1; tdi = 1'b1;
        tick();
        reset_n = 1'b1; shift_dr = 1'b0;
        chk("mid_rst_tdo", tdo1, 1'b0);
        chk("mid_rst_upd_valid", uv1, 1'b0);
        chk("mid_rst_len_err", le1, 1'b0);
        mode = 2'b01; #1;
        chk("mid_rst_mode01", pout1, 8'h00);
        mode = 2'b10; #1;
        chk("mid_rst_mode10", pout1, 8'h00);
        mode = 2'b11; #1;
        chk("mid_rst_mode11", pout1, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
